if_fetch: RTL and testbench

Instruction-fetch stage directly upstream of instruction decode. It reads a 32-bit instruction one byte per cycle from the byte-wide unified memory port and assembles it little-endian. It presents the instruction and its PC to the IF/ID pipeline register, holding them until that register accepts. It also redirects the PC on a taken jump or branch from EX.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fetch.sv | 106 ++++++++++
 tb/tb_if_fetch.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and FSM encoding for the byte-serial instruction fetch stage.
package if_fetch_pkg;

  localparam int ADDR_W     = 32;
  localparam int INST_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int INST_BYTES = 4;

  localparam logic [ADDR_W-1:0] ZERO32     = '0;
  localparam logic              RST_ENABLE = 1'b1;

  typedef enum logic {
    IF_FETCH = 1'b0,
    IF_HOLD  = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: reads one byte per cycle from the unified memory port, assembles a
// little-endian word and offers it with its PC to IF/ID until accepted; EX jumps redirect.
//   state    | meaning
//   IF_FETCH | issuing byte reads at pc..pc+3 and capturing returning bytes
//   IF_HOLD  | instruction valid and offered to IF/ID, waiting for stall_in low
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              stall_in,
  input  logic              jump_in,
  input  logic [ADDR_W-1:0] jumpAddr_in,
  input  logic              memGrant_in,
  input  logic [BYTE_W-1:0] memData_in,
  output logic              memRe_out,
  output logic [ADDR_W-1:0] memAddr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              instValid_out
);

  localparam logic [2:0] BYTES_CNT = 3'(INST_BYTES);

  if_state_t         state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        issue_cnt;
  logic [2:0]        recv_cnt;
  logic              pending;
  logic [1:0]        pend_idx;
  logic [BYTE_W-1:0] byte_buf [0:2];
  logic              last_byte;

  always_comb begin
    memRe_out   = (state == IF_FETCH) && (issue_cnt < BYTES_CNT) && memGrant_in &&
                  !jump_in && (rst_in != RST_ENABLE);
    memAddr_out = memRe_out ? (pc + {29'b0, issue_cnt}) : ZERO32;
    last_byte   = (state == IF_FETCH) && pending && (pend_idx == 2'd3);
  end

  always_comb begin
    state_nxt = state;
    if (jump_in) begin
      state_nxt = IF_FETCH;
    end else begin
      case (state)
        IF_FETCH: if (last_byte) state_nxt = IF_HOLD;
        IF_HOLD:  if (!stall_in) state_nxt = IF_FETCH;
        default:  state_nxt = IF_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RST_ENABLE) state <= IF_FETCH;
    else                      state <= state_nxt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RST_ENABLE) begin
      pc            <= RESET_PC;
      issue_cnt     <= '0;
      recv_cnt      <= '0;
      pending       <= 1'b0;
      pend_idx      <= '0;
      byte_buf      <= '{default: '0};
      pc_out        <= ZERO32;
      inst_out      <= '0;
      instValid_out <= 1'b0;
    end else if (jump_in) begin
      // Redirect wins over capture and acceptance; the in-flight byte is dropped.
      pc            <= jumpAddr_in;
      issue_cnt     <= '0;
      recv_cnt      <= '0;
      pending       <= 1'b0;
      instValid_out <= 1'b0;
    end else if (state == IF_FETCH) begin
      pending <= memRe_out;
      if (memRe_out) begin
        pend_idx  <= issue_cnt[1:0];
        issue_cnt <= issue_cnt + 3'd1;
      end
      if (pending) begin
        recv_cnt <= recv_cnt + 3'd1;
        if (pend_idx == 2'd3) begin
          inst_out      <= {memData_in, byte_buf[2], byte_buf[1], byte_buf[0]};
          pc_out        <= pc;
          instValid_out <= 1'b1;
        end else begin
          byte_buf[pend_idx] <= memData_in;
        end
      end
    end else begin
      pending <= 1'b0;
      if (!stall_in) begin
        pc            <= pc + 32'd4;
        issue_cnt     <= '0;
        recv_cnt      <= '0;
        instValid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed timing scenarios followed by random grant/stall/jump traffic.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        stall_in = 1'b0;
  logic        jump_in = 1'b0;
  logic [31:0] jumpAddr_in = '0;
  logic        memGrant_in = 1'b0;
  logic [7:0]  memData_in = '0;
  logic        memRe_out;
  logic [31:0] memAddr_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        instValid_out;

  always #5 clk_in = ~clk_in;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .jump_in(jump_in),
    .jumpAddr_in(jumpAddr_in), .memGrant_in(memGrant_in), .memData_in(memData_in),
    .memRe_out(memRe_out), .memAddr_out(memAddr_out), .pc_out(pc_out),
    .inst_out(inst_out), .instValid_out(instValid_out)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          presented = 0;
  logic [31:0] fetch_pc = '0;
  int          k = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_pc = '0, held_inst = '0;
  logic        rq = 1'b0;
  logic [31:0] ra = '0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ (a[23:16] * 8'd5) ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory: data for an address issued in one cycle is stable through the next cycle.
  always @(negedge clk_in) begin
    rq = memRe_out;
    ra = memAddr_out;
  end
  always @(posedge clk_in) begin
    #2;
    memData_in = rq ? mem_byte(ra) : 8'($urandom);
  end

  // Monitor: address stream, hold stability and scoreboard pops on each new presentation.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in) begin
      prev_valid = 1'b0;
    end else begin
      if (jump_in) chk("re_on_jump", 32'(memRe_out), 32'd0);
      if (memRe_out) begin
        chk("issue_count", 32'(k < 4), 32'd1);
        chk("addr", memAddr_out, fetch_pc + 32'(k));
        k++;
      end
      if (instValid_out && prev_valid) begin
        chk("hold_pc", pc_out, held_pc);
        chk("hold_inst", inst_out, held_inst);
        chk("hold_re", 32'(memRe_out), 32'd0);
      end else if (instValid_out) begin
        presented++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst actual=%h required=none", pc_out);
        end else begin
          e = exp_q.pop_front();
          chk("pc_out", pc_out, e.pc);
          chk("inst_out", inst_out, e.inst);
        end
        held_pc   = pc_out;
        held_inst = inst_out;
      end
      prev_valid = instValid_out;
    end
  end

  task automatic model_reset();
    exp_q.delete();
    fetch_pc = 32'h0;
    k = 0;
    exp_q.push_back('{32'h0, word_at(32'h0)});
  endtask

  task automatic step(input logic j, input logic [31:0] ja, input logic g, input logic s,
                      output logic re, output logic [31:0] addr, output logic v);
    logic vb;
    jump_in = j; jumpAddr_in = ja; memGrant_in = g; stall_in = s;
    vb = instValid_out;
    @(negedge clk_in);
    re = memRe_out; addr = memAddr_out; v = instValid_out;
    @(posedge clk_in); #1;
    if (j) begin
      exp_q.delete();
      fetch_pc = ja;
      k = 0;
      exp_q.push_back('{ja, word_at(ja)});
    end else if (vb && !s) begin
      fetch_pc = fetch_pc + 32'd4;
      k = 0;
      exp_q.push_back('{fetch_pc, word_at(fetch_pc)});
    end
  endtask

  task automatic wait_valid(input logic s);
    logic re, v; logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 32'h0, 1'b1, s, re, a, v);
      if (v) return;
    end
    chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic re, v; logic [31:0] a;
    int p0;
    memGrant_in = 1'b1;
    #2;
    chk("rst_re", 32'(memRe_out), 32'd0);
    chk("rst_addr", memAddr_out, 32'd0);
    chk("rst_valid", 32'(instValid_out), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();

    // Basic fetch with grant always high.
    for (int c = 0; c <= 6; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, re, a, v);
      chk("t1_re", 32'(re), 32'((c < 4) || (c == 6)));
      if (re) chk("t1_addr", a, (c == 6) ? 32'd4 : 32'(c));
      chk("t1_valid", 32'(v), 32'(c == 5));
    end

    // Stall while holding.
    wait_valid(1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, re, a, v);
      chk("t2_stall_re", 32'(re), 32'd0);
      chk("t2_stall_valid", 32'(v), 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, re, a, v);
    chk("t2_accept_valid", 32'(v), 32'd1);

    // Grant low in cycles 1-2.
    for (int c = 0; c <= 7; c++) begin
      step(1'b0, 32'h0, !(c == 1 || c == 2), 1'b0, re, a, v);
      chk("t3_re", 32'(re), 32'((c == 0) || (c >= 3 && c <= 5)));
      if (re) chk("t3_addr", a, (c == 0) ? 32'd8 : 32'd8 + 32'(c - 2));
      chk("t3_valid", 32'(v), 32'(c == 7));
    end

    // Jump in cycle 2 of a fetch.
    for (int c = 0; c <= 7; c++) begin
      step(c == 2, 32'h100, 1'b1, 1'b0, re, a, v);
      chk("t4_re", 32'(re), 32'(c != 2 && c <= 6));
      if (re) chk("t4_addr", a, (c < 2) ? 32'd12 + 32'(c) : 32'h100 + 32'(c - 3));
      chk("t4_valid", 32'(v), 32'd0);
    end
    // Jump coincident with acceptance.
    step(1'b1, 32'h200, 1'b1, 1'b0, re, a, v);
    chk("t5_valid", 32'(v), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, re, a, v);
    chk("t5_re", 32'(re), 32'd1);
    chk("t5_addr", a, 32'h200);

    // PC wrap-around after acceptance.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, re, a, v);
    wait_valid(1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, re, a, v);
    step(1'b0, 32'h0, 1'b1, 1'b0, re, a, v);
    chk("t6_re", 32'(re), 32'd1);
    chk("t6_addr", a, 32'h0);

    // Asynchronous reset mid-fetch.
    step(1'b0, 32'h0, 1'b1, 1'b0, re, a, v);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t7_re", 32'(memRe_out), 32'd0);
    chk("t7_addr", memAddr_out, 32'd0);
    chk("t7_valid", 32'(instValid_out), 32'd0);
    chk("t7_pc_out", pc_out, 32'd0);
    chk("t7_inst_out", inst_out, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, re, a, v);
    chk("t7_restart_re", 32'(re), 32'd1);
    chk("t7_restart_addr", a, 32'h0);
    wait_valid(1'b0);

    // Random traffic against the scoreboard.
    p0 = presented;
    for (int i = 0; i < 3000; i++) begin
      logic        j;
      logic [31:0] ja;
      j  = ($urandom_range(0, 99) < 3);
      ja = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      step(j, ja, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), re, a, v);
    end
    chk("random_progress", 32'((presented - p0) >= 50), 32'd1);

    jump_in = 1'b0; memGrant_in = 1'b0; stall_in = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
